// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule types, round-key counts and last-index helper.
package aes_key_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2
    } key_len_e;

    localparam int unsigned NUM_KEYS_128  = 11;
    localparam int unsigned NUM_KEYS_192  = 13;
    localparam int unsigned NUM_KEYS_256  = 15;
    localparam int unsigned KEY_IDX_WIDTH = 4;

    // Unknown encodings fall back to the AES-128 schedule.
    function automatic logic [KEY_IDX_WIDTH-1:0] last_key_idx(input key_len_e kl);
        logic [KEY_IDX_WIDTH-1:0] idx;
        case (kl)
            KEY_192: idx = KEY_IDX_WIDTH'(NUM_KEYS_192 - 1);
            KEY_256: idx = KEY_IDX_WIDTH'(NUM_KEYS_256 - 1);
            default: idx = KEY_IDX_WIDTH'(NUM_KEYS_128 - 1);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rks_read_port.sv
// One read channel: array read stage, then output stage, with miss masking.
// Same-cycle write forwarding is built only when RKS_WR_BYPASS_EN is defined.
module rks_read_port
    import aes_key_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 15,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic [DEPTH*DATA_WIDTH-1:0] mem_flat,
    input  logic [DEPTH-1:0]            valid_map,
`ifdef RKS_WR_BYPASS_EN
    input  logic                        wr_accept_c,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
`endif
    output logic                        rd_valid,
    output logic                        rd_hit,
    output logic [DATA_WIDTH-1:0]       rd_data
);

    logic                  hit_c;
    logic [DATA_WIDTH-1:0] data_c;
    logic                  s1_valid;
    logic                  s1_hit;
    logic [DATA_WIDTH-1:0] s1_data;

    // Entry lookup; out-of-range addresses match nothing and miss.
    always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        for (int e = 0; e < int'(DEPTH); e++) begin
            if (32'(rd_addr) == 32'(e)) begin
                hit_c  = valid_map[e];
                data_c = mem_flat[e*DATA_WIDTH +: DATA_WIDTH];
            end
        end
`ifdef RKS_WR_BYPASS_EN
        if (wr_accept_c && (wr_addr == rd_addr)) begin
            hit_c  = 1'b1;
            data_c = wr_data;
        end
`endif
        if (!hit_c) begin
            data_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_data  <= '0;
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            s1_hit   <= rd_en && hit_c;
            s1_data  <= rd_en ? data_c : '0;
            rd_valid <= s1_valid;
            rd_hit   <= s1_hit;
            rd_data  <= s1_data;
        end
    end

endmodule

// File: rtl/round_key_store.sv
// Multi-port AES round-key store with valid tracking and bulk clear.
// Optional same-cycle write-to-read forwarding: define RKS_WR_BYPASS_EN.
module round_key_store
    import aes_key_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 15,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [1:0]                   key_len,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_err,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [NUM_RD-1:0]            rd_hit,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [DEPTH-1:0]             valid_map,
    output logic                         all_loaded
);

    logic [DEPTH*DATA_WIDTH-1:0] mem_q;
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_nxt_c;
    logic [KEY_IDX_WIDTH-1:0]    last_idx_c;
    logic                        wr_accept_c;

    assign last_idx_c  = last_key_idx(key_len_e'(key_len));
    assign wr_accept_c = wr_en && (32'(wr_addr) <= 32'(last_idx_c));
    assign valid_map   = valid_q;

    // Storage carries no reset; validity lives in valid_q.
    always_ff @(posedge clk) begin
        for (int e = 0; e < int'(DEPTH); e++) begin
            if (wr_accept_c && (32'(wr_addr) == 32'(e))) begin
                mem_q[e*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
            end
        end
    end

    // Clear first, then the accepted write marks its entry.
    always_comb begin
        valid_nxt_c = clear ? '0 : valid_q;
        for (int e = 0; e < int'(DEPTH); e++) begin
            if (wr_accept_c && (32'(wr_addr) == 32'(e))) begin
                valid_nxt_c[e] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            wr_err  <= 1'b0;
        end else begin
            valid_q <= valid_nxt_c;
            wr_err  <= wr_en && !wr_accept_c;
        end
    end

    always_comb begin
        all_loaded = 1'b1;
        for (int e = 0; e < int'(DEPTH); e++) begin
            if ((32'(e) <= 32'(last_idx_c)) && !valid_q[e]) begin
                all_loaded = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        rks_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_en      (rd_en[i]),
            .rd_addr    (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .mem_flat   (mem_q),
            .valid_map  (valid_q),
`ifdef RKS_WR_BYPASS_EN
            .wr_accept_c(wr_accept_c),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
`endif
            .rd_valid   (rd_valid[i]),
            .rd_hit     (rd_hit[i]),
            .rd_data    (rd_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store with hand-computed expected values.
module tb_round_key_store;

    localparam int unsigned DW = 128;
    localparam int unsigned DEPTH = 15;
    localparam int unsigned NRD = 2;
    localparam int unsigned AW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic [1:0]        key_len;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_err;
    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]    rd_valid;
    logic [NRD-1:0]    rd_hit;
    logic [NRD*DW-1:0] rd_data;
    logic [DEPTH-1:0]  valid_map;
    logic              all_loaded;

    int vectors = 0;
    int miscompares = 0;

    round_key_store #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .key_len(key_len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_hit(rd_hit),
        .rd_data(rd_data), .valid_map(valid_map), .all_loaded(all_loaded)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] kdat(input int i);
        logic [31:0] w;
        w = 32'h0000_00A0 + 32'(i);
        return {4{w}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 256'(rd_valid), 256'(0));
        chk({tag, "_hit"}, 256'(rd_hit), 256'(0));
        chk({tag, "_data"}, 256'(rd_data), 256'(0));
    endtask

    logic [DW-1:0] x_dat, y_dat, d5;

    initial begin
        rst_n = 1'b0; clear = 1'b0; key_len = 2'd0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
        x_dat = {4{32'hDEAD_0007}};
        y_dat = {4{32'hBEEF_0007}};
        d5    = {4{32'h5555_0005}};
        tick(); tick();
        chk_idle("reset");
        chk("reset_wr_err", 256'(wr_err), 256'(0));
        chk("reset_valid_map", 256'(valid_map), 256'(0));
        chk("reset_all_loaded", 256'(all_loaded), 256'(0));
        rst_n = 1'b1;
        tick();

        // Read of empty store misses on both channels.
        rd_en = 2'b11; rd_addr = '0;
        tick();
        rd_en = '0;
        tick();
        chk("empty_rd_valid", 256'(rd_valid), 256'(2'b11));
        chk("empty_rd_hit", 256'(rd_hit), 256'(0));
        chk("empty_rd_data", 256'(rd_data), 256'(0));
        tick();
        chk_idle("empty_after");

        // AES-128 load.
        for (int i = 0; i <= 10; i++) begin
            if (i == 10) chk("load_pre_all_loaded", 256'(all_loaded), 256'(0));
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = kdat(i);
            tick();
        end
        wr_en = 1'b0;
        chk("load_all_loaded", 256'(all_loaded), 256'(1));
        chk("load_valid_map", 256'(valid_map), 256'(15'h07FF));

        rd_en = 2'b11; rd_addr = {4'd10, 4'd3};
        tick();
        rd_en = '0;
        tick();
        chk("rd3_10_valid", 256'(rd_valid), 256'(2'b11));
        chk("rd3_10_hit", 256'(rd_hit), 256'(2'b11));
        chk("rd3_10_data", 256'(rd_data), {kdat(10), kdat(3)});

        // Out-of-range writes under AES-128.
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = kdat(12);
        tick();
        wr_en = 1'b0;
        chk("oor12_wr_err", 256'(wr_err), 256'(1));
        chk("oor12_valid_map", 256'(valid_map), 256'(15'h07FF));
        tick();
        chk("oor12_wr_err_clr", 256'(wr_err), 256'(0));
        wr_en = 1'b1; wr_addr = 4'd15;
        tick();
        wr_en = 1'b0;
        chk("oor15_wr_err", 256'(wr_err), 256'(1));

        // key_len 3 behaves as AES-128; AES-256 re-evaluates all_loaded at once.
        key_len = 2'd3; #1;
        chk("klen3_all_loaded", 256'(all_loaded), 256'(1));
        key_len = 2'd2; #1;
        chk("klen2_all_loaded", 256'(all_loaded), 256'(0));
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = kdat(12);
        tick();
        wr_en = 1'b0;
        chk("w12_256_wr_err", 256'(wr_err), 256'(0));
        chk("w12_256_valid_map", 256'(valid_map), 256'(15'h17FF));

        // ch0 out of range, ch1 newly written entry.
        rd_en = 2'b11; rd_addr = {4'd12, 4'd15};
        tick();
        rd_en = '0;
        tick();
        chk("rd15_12_hit", 256'(rd_hit), 256'(2'b10));
        chk("rd15_12_data", 256'(rd_data), {kdat(12), 128'(0)});

        // Clear with simultaneous write.
        key_len = 2'd0;
        clear = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = d5;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        chk("clr_valid_map", 256'(valid_map), 256'(15'h0020));
        chk("clr_all_loaded", 256'(all_loaded), 256'(0));
        rd_en = 2'b11; rd_addr = {4'd5, 4'd4};
        tick();
        rd_en = '0;
        tick();
        chk("clr_rd_valid", 256'(rd_valid), 256'(2'b11));
        chk("clr_rd_hit", 256'(rd_hit), 256'(2'b10));
        chk("clr_rd_data", 256'(rd_data), {d5, 128'(0)});

        // Same-address read/write, plus back-to-back reads on ch0.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = x_dat;
        tick();
        wr_data = y_dat; rd_en = 2'b11; rd_addr = {4'd7, 4'd7};
        tick();
        wr_en = 1'b0; rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
        tick();
        rd_en = '0;
        chk("rw7_hit", 256'(rd_hit), 256'(2'b11));
`ifdef RKS_WR_BYPASS_EN
        chk("rw7_data", 256'(rd_data), {y_dat, y_dat});
`else
        chk("rw7_data", 256'(rd_data), {x_dat, x_dat});
`endif
        tick();
        chk("b2b_valid", 256'(rd_valid), 256'(2'b01));
        chk("b2b_data", 256'(rd_data), {128'(0), d5});
        tick();
        chk_idle("b2b_idle");

        // Reset one cycle after a read request.
        rd_en = 2'b11; rd_addr = {4'd7, 4'd5};
        tick();
        rd_en = '0;
        rst_n = 1'b0; #1;
        chk_idle("midrst");
        chk("midrst_valid_map", 256'(valid_map), 256'(0));
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_rd_valid", 256'(rd_valid), 256'(0));
        end
        chk("post_rst_data", 256'(rd_data), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/round_key_store.md
# round_key_store

Multi-port, mode-aware round-key storage for the AES datapath. The key-expansion engine writes it once per key, and one or more round pipelines read it concurrently. It generalises single-port key memory in four ways: separate write and read ports, `NUM_RD` independent read channels, per-entry valid tracking with a key-length-dependent "fully loaded" flag, and a bulk clear for rekeying. Read data is returned with a fixed two-cycle registered latency.

## Interface
Parameters:
- `DATA_WIDTH`, 128: round-key width in bits.
- `DEPTH`, 15: number of entries; must be ≥ 15 to hold AES-256 (15 round keys).
- `NUM_RD`, 2: number of independent read channels, 1..4.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: entry index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: invalidates all entries (rekey).
- `key_len` in 2: 0 = AES-128 (11 keys), 1 = AES-192 (13 keys), 2 = AES-256 (15 keys); 3 is treated as 0.
- `wr_en` in 1: write strobe.
- `wr_addr` in `ADDR_WIDTH`: write index.
- `wr_data` in `DATA_WIDTH`: round key to write.
- `wr_err` out 1: registered one-cycle pulse; the write was rejected.
- `rd_en` in `NUM_RD`: per-channel read request.
- `rd_addr` in `NUM_RD*ADDR_WIDTH`: channel i uses bits `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `rd_valid` out `NUM_RD`: response strobe per channel.
- `rd_hit` out `NUM_RD`: the entry read was valid.
- `rd_data` out `NUM_RD*DATA_WIDTH`: channel i uses bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `valid_map` out `DEPTH`: per-entry valid bits.
- `all_loaded` out 1: entries 0..last_idx are all valid.

## Operation
- **Storage.** Storage is a `DEPTH` × `DATA_WIDTH` register array and is not reset. `valid_map` is reset to 0.
- **last_idx.** `last_idx` is 10, 12 or 14 according to `key_len`.
- **Write acceptance.** A write with `wr_en=1` is accepted when `wr_addr` ≤ `last_idx`. An accepted write stores `wr_data` and sets `valid_map[wr_addr]` at the edge.
- **Write rejection.** A write with `wr_addr` > `last_idx` (including ≥ `DEPTH`) is dropped, and `wr_err` pulses 1 on the next cycle.
- **Clear.** `clear=1` zeroes `valid_map` at the edge.
  - If `wr_en` is also set, the clear applies first and the accepted write then sets its bit. The result is exactly one valid entry.
- **Read hit/miss.** Each channel is independent. A read with `rd_en[i]=1` samples `mem` and `valid_map` as they were before the edge.
  - On a hit, the response returns the data.
  - If the entry is invalid or the address is out of range, `rd_hit[i]=0` and `rd_data` for that channel is forced to 0.
- **Stall-free.** All channels may read the same address in the same cycle. There is no backpressure.
- **all_loaded.** `all_loaded` is combinational from `valid_map` and `key_len`.
  - Changing `key_len` does not clear entries, but it re-evaluates `all_loaded` and the write limit immediately.

## Timing
- **Read latency.** A request in cycle N produces `rd_valid[i]=1` with `rd_hit`/`rd_data` in cycle N+2. There are two register stages: array read, then output register.
  - Back-to-back reads give one response per cycle per channel.
  - In cycles with no response, `rd_valid=0`, `rd_hit=0` and `rd_data=0`.
- **Read/write same address, same cycle.** Without bypass, the read returns the old contents and old valid bit (see Configuration).
- **Reset.**
  - During reset: all outputs 0, both pipeline stages flushed, `valid_map=0`.
  - Reset asserted mid-read discards in-flight responses. No `rd_valid` appears after `rst_n` rises unless a new request is made.
- **Latencies of flags.**
  - `wr_err`: one cycle after the write attempt.
  - `valid_map`/`all_loaded`: update one cycle after the write or clear edge.

## Configuration
- **`RKS_WR_BYPASS_EN` defined.** A read whose address matches an accepted same-cycle write returns `wr_data` with `rd_hit=1`, two cycles later. This also applies when a `clear` occurs in the same cycle.
- **Undefined.** Such a read returns the pre-write contents and pre-write valid bit. There is no forwarding logic.

## Structure
- **Package `aes_key_pkg`.**
  - `key_len_e` enum: `KEY_128`, `KEY_192`, `KEY_256`.
  - Constants `NUM_KEYS_128`/`192`/`256` = 11/13/15.
  - Function `last_key_idx(key_len_e)`.
- **Sub-module `rks_read_port`.** One instance per channel. It contains the two-stage read pipeline, the hit/zero masking and the optional bypass compare. The top level holds the array, `valid_map`, the write checks and `all_loaded`.

## Test plan
- **Reset.** Reset, then read addr 0 on all channels → after 2 cycles `rd_valid=1`, `rd_hit=0`, `rd_data=0`; `all_loaded=0`.
- **AES-128 load.** `key_len=0`; write keys 0..10 with data `32'hA0+i` replicated → `all_loaded=1` one cycle after the last write. Ch0 reads 3 and ch1 reads 10 in the same cycle → both return the correct data at N+2.
- **Out-of-range writes.** `key_len=0`, write addr 12 → `wr_err=1` for one cycle, `valid_map[12]=0`. With `key_len=2` the same write is accepted.
- **Clear with write.** `clear=1` together with a write to addr 5 → `valid_map` = only bit 5; `all_loaded=0`; a read of addr 4 misses.
- **Same-address read/write.** Addr 7 holds X; write Y to 7 while reading 7 → returns Y if `RKS_WR_BYPASS_EN` is defined, X otherwise.
- **Reset mid-read.** Assert `rst_n=0` one cycle after a read request → no `rd_valid` after release; all outputs 0.
